// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way bus arbiter.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed a>b>c>d priority in rr_pick4).
package arb_pkg;
  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 4;
  localparam int DATA_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot strobe for a requester index.
  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/bus_arbiter4way16_rr_pick4.sv
// Combinational requester picker.
// Default: round-robin search starting just after 'last', wrapping.
// With ARB_FIXED_PRIO_EN defined: fixed priority a>b>c>d, 'last' is ignored.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             any
);
`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  // Lowest set index wins; scan downwards so the lowest overwrites last.
  always_comb begin
    any  = |req;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) pick = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] cand;

  // Search offsets last+1 .. last+4; scan from the far end so the nearest wins.
  always_comb begin
    any  = |req;
    pick = '0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) pick = cand;
    end
  end
`endif
endmodule

// File: rtl/mux4way16.sv
// Plain 4-way 16-bit data multiplexer; select 0..3 picks a..d.
module mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);
  // Route the selected input straight through.
  always_comb begin
    out = a;
    case (sel)
      2'd0: out = a;
      2'd1: out = b;
      2'd2: out = c;
      2'd3: out = d;
      default: out = a;
    endcase
  end
endmodule

// File: rtl/bus_arbiter4way16.sv
// Round-robin arbiter sharing one registered 16-bit output between four
// requesters, with a valid/ready output stage and a per-grant beat limit.
// Optional build macro: ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module bus_arbiter4way16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [N_REQ-1:0]  ack,
  output logic [IDX_W-1:0]  sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready
);
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [DATA_W-1:0]  mux_out;
  logic               space;
  logic               beat;
  logic               last_beat;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  mux4way16 u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel_q),
    .out (mux_out)
  );

  // A beat is taken when the granted requester asks and the output slot is free
  // (empty, or being drained this very cycle).
  assign space     = !out_valid_q || out_ready;
  assign beat      = (state_q == GRANT) && req[sel_q] && space;
  assign last_beat = (hold_q == HOLD_W'(MAX_HOLD - 1));

  // State register: arbitration state plus output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      hold_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: arbitrate in IDLE, release on hold limit or dropped request.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = pick;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (beat) begin
          if (last_beat) begin
            // Clear the counter on release so it never reaches MAX_HOLD.
            hold_d  = '0;
            last_d  = sel_q;
            state_d = IDLE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else if (!req[sel_q]) begin
          last_d  = sel_q;
          state_d = IDLE;
        end
        // Stalled with request held: keep grant and count untouched.
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: accept strobe and output-stage next values.
  always_comb begin
    ack         = '0;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (beat) begin
      ack         = idx_onehot(sel_q);
      out_d       = mux_out;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign sel       = sel_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_bus_arbiter4way16.sv
// Self-checking bench for bus_arbiter4way16: directed opening sequence, then
// randomized requests/backpressure/resets against a behavioural model.
module tb_bus_arbiter4way16;
`ifdef ARB_FIXED_PRIO_EN
  localparam int MH = 2;
`else
  localparam int MH = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] a, b, c, d;
  logic [3:0]  ack;
  logic [1:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state (values the DUT registers should hold now).
  bit          m_busy;
  int          m_sel, m_last, m_cnt;
  logic [15:0] m_out;
  bit          m_valid;
  int          d_grants;

  bus_arbiter4way16 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ack       (ack),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_last = 3; m_cnt = 0; m_out = '0; m_valid = 0;
  endtask

  function automatic int model_pick(input logic [3:0] r, input int last);
    int p;
    p = -1;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (p < 0 && r[i]) p = i;
`else
    for (int k = 1; k <= 4; k++) if (p < 0 && r[(last + k) % 4]) p = (last + k) % 4;
`endif
    return p;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rst, input logic [3:0] rq, input logic rdy,
                      input logic [15:0] da, input logic [15:0] db,
                      input logic [15:0] dc, input logic [15:0] dd);
    logic [15:0] data [4];
    logic [3:0]  exp_ack;
    bit          took;
    reset = rst; req = rq; out_ready = rdy; a = da; b = db; c = dc; d = dd;
    data[0] = da; data[1] = db; data[2] = dc; data[3] = dd;
    #2;
    took    = m_busy && rq[m_sel] && (!m_valid || rdy);
    exp_ack = took ? (4'b0001 << m_sel) : 4'b0000;
    check("ack", {28'd0, ack}, {28'd0, exp_ack});
    check("sel", {30'd0, sel}, m_sel);
    check("out", {16'd0, out}, {16'd0, m_out});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    $display("[TB] t=%0t rst=%b req=%b rdy=%b ack=%b sel=%0d out=%h v=%b",
             $time, rst, rq, rdy, ack, sel, out, out_valid);
    if (rst) begin
      model_reset();
    end else begin
      if (took) begin
        m_out = data[m_sel]; m_valid = 1; m_cnt++;
      end else if (rdy) begin
        m_valid = 0;
      end
      if (!m_busy) begin
        if (rq != 4'b0) begin
          m_sel = model_pick(rq, m_last); m_cnt = 0; m_busy = 1;
          if (m_sel == 3) d_grants++;
        end
      end else if (took && m_cnt == MH) begin
        m_busy = 0; m_last = m_sel; m_cnt = 0;
      end else if (!rq[m_sel]) begin
        m_busy = 0; m_last = m_sel;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] rq;
    reset = 1'b1; req = '0; out_ready = 1'b0; a = '0; b = '0; c = '0; d = '0;
    d_grants = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);

    // First transaction: ack one cycle after request, data the cycle after.
    step(1'b0, 4'b0001, 1'b1, 16'h1234, 16'h0, 16'h0, 16'h0);
    step(1'b0, 4'b0001, 1'b1, 16'h1234, 16'h0, 16'h0, 16'h0);
    check("t1_out", {16'd0, out}, 32'h1234);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_sel", {30'd0, sel}, 32'd0);
    step(1'b0, 4'b0000, 1'b1, 16'h1234, 16'h0, 16'h0, 16'h0);
    step(1'b0, 4'b0000, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);

    // Saturated requests, full throughput: bursts rotate through all four.
    for (int i = 0; i < 24; i++)
      step(1'b0, 4'b1111, 1'b1, 16'hA000 + 16'(i), 16'hB000 + 16'(i),
           16'hC000 + 16'(i), 16'hD000 + 16'(i));

    // Reset in the middle of a burst, then a two-requester pattern.
    step(1'b0, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    step(1'b1, 4'b1111, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out", {16'd0, out}, 32'd0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'b1010, 1'b1, 16'h1, 16'h2, 16'h3, 16'h4);

    // Randomized requests, backpressure, drops and occasional reset.
    rq = 4'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) != 0) rq = 4'($urandom);
      step(($urandom_range(79) == 0), rq, ($urandom_range(3) != 0),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

`ifdef ARB_FIXED_PRIO_EN
    // a and d always requesting: a must win every arbitration.
    d_grants = 0;
    for (int i = 0; i < 20; i++)
      step(1'b0, 4'b1001, 1'b1, 16'h00AA, 16'h0, 16'h0, 16'h00DD);
    check("starve_sel", {30'd0, sel}, 32'd0);
    check("starve_d", d_grants, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
